// File: rtl/router_input_port.sv
// Per-port receive stage: deserializes bit-serial frames into {da, data}
// packets and queues them in a small FIFO in front of the crossbar.
module router_input_port #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_n,
    input  logic                     valid_n,
    input  logic                     di,
    output logic                     pkt_valid,
    output logic [2:0]               pkt_da,
    output logic [31:0]              pkt_data,
    input  logic                     pkt_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} state_t;

    state_t        state;
    logic          armed;
    logic [1:0]    addr_idx;
    logic [4:0]    bit_idx;
    logic [2:0]    da_q;
    logic [31:0]   data_q;

    logic [34:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [34:0]   head;

    logic complete;
    logic full;
    logic pop;
    logic push_ok;

    assign complete = (state == DATA) && frame_n && (bit_idx == 5'd31);
    assign full     = (fifo_count == (PW+1)'(DEPTH));
    assign pop      = pkt_valid && pkt_ready;
    assign push_ok  = complete && (!full || pop);

    // Receiver control; the arm flag keeps a frame already in flight at
    // reset release from being misread as a new one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            addr_idx <= 2'd0;
            bit_idx  <= 5'd0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (frame_n)
                armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && !frame_n) begin
                        addr_idx <= 2'd1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (frame_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (!valid_n) begin
                        err   <= 1'b1;
                        state <= DROP;
                    end else if (addr_idx == 2'd2) begin
                        state <= PAD;
                    end else begin
                        addr_idx <= addr_idx + 2'd1;
                    end
                end
                PAD: begin
                    if (frame_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (!valid_n) begin
                        bit_idx <= 5'd1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (frame_n) begin
                        err   <= (bit_idx != 5'd31);
                        state <= IDLE;
                    end else if (!valid_n) begin
                        if (bit_idx == 5'd31) begin
                            err   <= 1'b1;
                            state <= DROP;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end
                end
                DROP: begin
                    if (frame_n)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift-in datapath; contents are only meaningful once a frame completes.
    always_ff @(posedge clock) begin
        if (state == IDLE && armed && !frame_n)
            da_q[0] <= di;
        if (state == ADDR && !frame_n && valid_n)
            da_q[addr_idx] <= di;
        if (state == PAD && !frame_n && !valid_n)
            data_q[0] <= di;
        if (state == DATA && !frame_n && !valid_n && bit_idx != 5'd31)
            data_q[bit_idx] <= di;
        if (push_ok)
            mem[wr_ptr] <= {da_q, di, data_q[30:0]};
    end

    // FIFO bookkeeping; a pop on the completion edge frees room for the push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            ovf <= complete && full && !pop;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign pkt_valid = (fifo_count != '0);
    assign pkt_da    = pkt_valid ? head[34:32] : 3'd0;
    assign pkt_data  = pkt_valid ? head[31:0]  : 32'd0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: stimulus pushes expected packets to a
// scoreboard queue, an independent monitor pops them as the DUT delivers.
module tb_router_input_port;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        frame_n;
    logic        valid_n;
    logic        di;
    logic        pkt_valid;
    logic [2:0]  pkt_da;
    logic [31:0] pkt_data;
    logic        pkt_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        err;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [34:0] sb[$];

    router_input_port #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .di         (di),
        .pkt_valid  (pkt_valid),
        .pkt_da     (pkt_da),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .err        (err),
        .ovf        (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        di      = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [2:0] da, input logic [31:0] data, input int pads,
                              input int st_a, input int st_b, input bit drop, input bit ready_last);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, da[i]);
        for (int i = 0; i < pads; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 31; b++) begin
            cyc(1'b0, 1'b0, data[b]);
            if (b == st_a || b == st_b) cyc(1'b0, 1'b1, 1'b1);
        end
        if (ready_last) pkt_ready = 1'b1;
        cyc(1'b1, 1'b0, data[31]);
        if (ready_last) pkt_ready = 1'b0;
        chk("ovf_at_completion", ovf, drop);
        chk("err_at_completion", err, 0);
        if (!drop) sb.push_back({da, data});
    endtask

    task automatic drain();
        pkt_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_count != 0; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("drain_count", fifo_count, 0);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    // Monitor: a head accepted at the coming edge must match the oldest expectation.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pkt: got da=%0h data=%0h expected none", pkt_da, pkt_data);
                end else begin
                    e = sb.pop_front();
                    chk("head_da", pkt_da, e[34:32]);
                    chk("head_data", pkt_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; di = 1'b0; pkt_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_da", pkt_da, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);

        // Smoke
        pkt_ready = 1'b1;
        send_frame(3'd7, 32'hdead_beef, 1, -1, -1, 0, 0);
        chk("smoke_valid", pkt_valid, 1);
        chk("smoke_da", pkt_da, 3'd7);
        chk("smoke_data", pkt_data, 32'hdead_beef);
        cyc(1'b1, 1'b1, 1'b0);
        chk("smoke_valid_gone", pkt_valid, 0);

        // Overflow
        pkt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(3'(i), 32'h1000_0000 + 32'(i), 0, -1, -1, 0, 0);
        chk("ovf_count_full", fifo_count, 4);
        chk("ovf_head_da", pkt_da, 0);
        send_frame(3'd4, 32'h1000_0004, 0, -1, -1, 1, 0);
        chk("ovf_count_after", fifo_count, 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ovf_pulse_end", ovf, 0);
        drain();

        // Stalls and padding
        pkt_ready = 1'b1;
        send_frame(3'd5, 32'h9876_abcd, 3, 5, 20, 0, 0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);

        // Runt
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        for (int b = 0; b < 10; b++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("runt_err", err, 1);
        chk("runt_busy", busy, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("runt_err_end", err, 0);
        chk("runt_no_push", fifo_count, 0);

        // Overlength, then recovery
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 32; b++) cyc(1'b0, 1'b0, 1'b1);
        chk("overlen_err", err, 1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("drop_busy", busy, 1);
        chk("drop_err_end", err, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("drop_exit", busy, 0);
        chk("overlen_no_push", fifo_count, 0);
        send_frame(3'd3, 32'hcafe_cafe, 0, -1, -1, 0, 0);
        cyc(1'b1, 1'b1, 1'b0);

        // Reset mid-frame with a packet waiting
        pkt_ready = 1'b0;
        send_frame(3'd1, 32'h1111_2222, 0, -1, -1, 0, 0);
        chk("pre_reset_count", fifo_count, 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 15; b++) cyc(1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_da", pkt_da, 0);
        chk("mid_rst_data", pkt_data, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        cyc(1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        for (int b = 16; b < 31; b++) cyc(1'b0, 1'b0, 1'b1);
        chk("post_rst_ignored_busy", busy, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("post_rst_no_push", fifo_count, 0);
        chk("post_rst_no_err", err, 0);
        pkt_ready = 1'b1;
        send_frame(3'd2, 32'h0f0f_1234, 0, -1, -1, 0, 0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);

        // Full with simultaneous pop on the completion edge
        pkt_ready = 1'b0;
        for (int i = 4; i < 8; i++) send_frame(3'(i), 32'ha5a5_0000 + 32'(i), 1, -1, -1, 0, 0);
        chk("fullpop_pre_count", fifo_count, 4);
        send_frame(3'd1, 32'h5a5a_7777, 0, -1, -1, 0, 1);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_head_da", pkt_da, 3'd5);
        cyc(1'b1, 1'b1, 1'b0);
        chk("fullpop_no_ovf_late", ovf, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
